or_3: RTL and testbench

// - N-input OR reduction. Default N=3: s = a[2] | a[1] | a[0].
// - s is purely combinational and must match the 3-input OR truth table in zero time.
// - Adds a clocked shadow of the result: registered copy, rising-edge pulse, saturating

---
 rtl/or_3_pkg.sv | 13 +
 rtl/or_3_sat_cnt.sv | 42 ++++
 rtl/or_3.sv | 59 +++++
 tb/tb_or_3.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/or_3_pkg.sv
// ============================================================================
//  Module  : or_3_pkg
//  Purpose : Default parameter values shared by or_3 and its counter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package or_3_pkg;
   localparam int DEF_WIDTH = 3;
   localparam int DEF_CNT_W = 8;
endpackage : or_3_pkg

`default_nettype wire

// File: rtl/or_3_sat_cnt.sv
// ============================================================================
//  Module  : or_3_sat_cnt
//  Purpose : Up-counter with enable, synchronous active-low reset, saturating at all-ones.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module or_3_sat_cnt
   import or_3_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Holding at all-ones keeps the count from wrapping back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule : or_3_sat_cnt

`default_nettype wire

// File: rtl/or_3.sv
// ============================================================================
//  Module  : or_3
//  Purpose : WIDTH-input OR reduction with registered copy, rise pulse and
//            saturating count of asserted cycles.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module or_3
   import or_3_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   output logic             s,
   output logic             s_q,
   output logic             s_rise,
   output logic [CNT_W-1:0] act_cnt
);

   logic s_d;
   logic s_rise_d;
   logic s_rise_q;

   // Pure combinational path: independent of clock and reset.
   assign s = |a;

   always_comb begin
      s_d      = s;
      s_rise_d = s & ~s_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q      <= 1'b0;
         s_rise_q <= 1'b0;
      end else begin
         s_q      <= s_d;
         s_rise_q <= s_rise_d;
      end
   end

   assign s_rise = s_rise_q;

   or_3_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_sat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (s),
      .cnt   (act_cnt)
   );

endmodule : or_3

`default_nettype wire

// File: tb/tb_or_3.sv
// ============================================================================
//  Module  : tb_or_3
//  Purpose : Scoreboard bench for or_3 (default widths plus a CNT_W=2 copy).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_or_3;

   logic       clk;
   logic       rst_n;
   logic [2:0] a;

   logic       s_8, s_q_8, s_rise_8;
   logic [7:0] cnt_8;
   logic       s_2, s_q_2, s_rise_2;
   logic [1:0] cnt_2;

   int n_cmp;
   int n_bad;
   bit drv_done;

   typedef struct {
      logic s;
      logic sq;
      logic rise;
      int   cnt8;
      int   cnt2;
   } exp_t;

   exp_t exp_q[$];

   // Reference state: unbounded count, clipped to each counter's maximum on compare.
   int   m_cnt;
   logic m_sq;
   logic m_rise;

   or_3 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .s       (s_8),
      .s_q     (s_q_8),
      .s_rise  (s_rise_8),
      .act_cnt (cnt_8)
   );

   or_3 #(.WIDTH(3), .CNT_W(2)) dut_sat (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .s       (s_2),
      .s_q     (s_q_2),
      .s_rise  (s_rise_2),
      .act_cnt (cnt_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int min_i(input int x, input int y);
      return (x < y) ? x : y;
   endfunction

   // One cycle of stimulus, applied on the falling edge; expectation for the next rising edge.
   task automatic step(input logic [2:0] av, input logic rn);
      exp_t e;
      logic sv;
      @(negedge clk);
      a     = av;
      rst_n = rn;
      sv    = (av != 3'd0);
      if (!rn) begin
         m_cnt  = 0;
         m_sq   = 1'b0;
         m_rise = 1'b0;
      end else begin
         m_rise = sv && !m_sq;
         m_sq   = sv;
         if (sv) m_cnt = m_cnt + 1;
      end
      e.s    = sv;
      e.sq   = m_sq;
      e.rise = m_rise;
      e.cnt8 = min_i(m_cnt, 255);
      e.cnt2 = min_i(m_cnt, 3);
      exp_q.push_back(e);
   endtask

   // Monitor: after each rising edge, compare against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("s",        {31'd0, s_8},      {31'd0, e.s});
            chk("s_cnt2",   {31'd0, s_2},      {31'd0, e.s});
            chk("s_q",      {31'd0, s_q_8},    {31'd0, e.sq});
            chk("s_rise",   {31'd0, s_rise_8}, {31'd0, e.rise});
            chk("act_cnt",  {24'd0, cnt_8},    e.cnt8);
            chk("s_q_c2",   {31'd0, s_q_2},    {31'd0, e.sq});
            chk("s_rise_c2",{31'd0, s_rise_2}, {31'd0, e.rise});
            chk("act_cnt2", {30'd0, cnt_2},    e.cnt2);
         end
      end
   end

   initial begin
      logic [2:0] tv;
      n_cmp    = 0;
      n_bad    = 0;
      drv_done = 1'b0;
      m_cnt    = 0;
      m_sq     = 1'b0;
      m_rise   = 1'b0;
      rst_n    = 1'b0;
      a        = 3'd0;

      // Combinational truth table, stepped every 5 ns, with reset held.
      for (int i = 0; i < 8; i++) begin
         tv = i[2:0];
         a  = tv;
         #1;
         chk("truth_s", {31'd0, s_8}, {31'd0, (i != 0)});
         #4;
      end

      // Reset for 2 clocks, then 000 -> 001.
      step(3'b000, 1'b0);
      step(3'b000, 1'b0);
      step(3'b000, 1'b1);
      step(3'b001, 1'b1);
      step(3'b001, 1'b1);

      // Counter run: 100 for 5 clocks, 000 for 3 clocks, after a fresh reset.
      step(3'b000, 1'b0);
      for (int i = 0; i < 5; i++) step(3'b100, 1'b1);
      for (int i = 0; i < 3; i++) step(3'b000, 1'b1);

      // Saturation on the narrow counter: 111 for 6 clocks.
      step(3'b000, 1'b0);
      for (int i = 0; i < 6; i++) step(3'b111, 1'b1);

      // Mid-run reset with count 4 and s_q high; s keeps tracking a during reset.
      step(3'b000, 1'b0);
      for (int i = 0; i < 4; i++) step(3'b010, 1'b1);
      step(3'b110, 1'b0);
      step(3'b000, 1'b1);

      // Toggle 000/010 each clock: rise pulse every other clock.
      for (int i = 0; i < 10; i++) step((i % 2 == 1) ? 3'b010 : 3'b000, 1'b1);

      // Random traffic with occasional reset.
      for (int i = 0; i < 300; i++) begin
         tv = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) tv = 3'd0;
         step(tv, ($urandom_range(0, 19) != 0));
      end

      drv_done = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_or_3

`default_nettype wire
